// File: rtl/si53xx_spi_responder.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
//  Module   : si53xx_spi_responder
//  Purpose  : SPI target that decodes command bytes (set address, write,
//             read) into a simple register strobe interface. The SPI pins
//             are oversampled on clk, so sclk must be much slower than clk.
//  Option   : define SI53XX_RESP_AUTOINC_EN to step reg_addr after each
//             register write and each completed read data byte.
//  Revision : 1.0  initial release
// ============================================================================
module si53xx_spi_responder #(
   parameter logic [7:0] SET_ADDR_CMD = 8'h15,
   parameter logic [7:0] WRITE_CMD    = 8'h4A,
   parameter logic [7:0] READ_CMD     = 8'h95,
   parameter bit         RD_LSB_FIRST = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       nCS,
   input  logic       sclk,
   input  logic       sdi,
   output logic       sdo,
   output logic       sdo_oe,
   output logic [7:0] reg_addr,
   output logic [7:0] reg_wdata,
   output logic       reg_we,
   output logic       reg_re,
   input  logic [7:0] reg_rdata,
   output logic       cmd_err,
   output logic       frame_abort
);

   typedef enum logic [1:0] {
      S_CMD   = 2'd0,
      S_ADDR  = 2'd1,
      S_WDATA = 2'd2,
      S_RDATA = 2'd3
   } state_t;

   state_t     state, state_nxt;
   logic [1:0] ncs_sync, sclk_sync, sdi_sync;
   logic       ncs_prev, sclk_prev;
   logic       ncs_fall, ncs_rise, sclk_rise, sclk_fall;
   logic       in_frame;
   logic [3:0] bit_cnt;
   logic [7:0] shift_in;
   logic       byte_done;
   logic       abort_cond;
   logic [7:0] rd_shift;
   logic       re_dly;
   logic       we_nxt, re_nxt, err_nxt, abort_nxt, addr_ld, wdata_ld;

   // Edges are taken from the synchronised copies against a one-cycle delay.
   assign ncs_fall  =  ncs_prev  & ~ncs_sync[1];
   assign ncs_rise  = ~ncs_prev  &  ncs_sync[1];
   assign sclk_rise = ~sclk_prev &  sclk_sync[1];
   assign sclk_fall =  sclk_prev & ~sclk_sync[1];

   // A frame cut short after some but not all 8 bits is abandoned.
   assign abort_cond = ncs_rise && in_frame && (bit_cnt != 4'd0) && (bit_cnt < 4'd8);

   assign sdo = sdo_oe & (RD_LSB_FIRST ? rd_shift[0] : rd_shift[7]);

   // Two-flop synchronisers plus the delayed copies used for edge detection.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ncs_sync  <= 2'b00;
         sclk_sync <= 2'b00;
         sdi_sync  <= 2'b00;
         ncs_prev  <= 1'b0;
         sclk_prev <= 1'b0;
      end else begin
         ncs_sync  <= {ncs_sync[0], nCS};
         sclk_sync <= {sclk_sync[0], sclk};
         sdi_sync  <= {sdi_sync[0], sdi};
         ncs_prev  <= ncs_sync[1];
         sclk_prev <= sclk_sync[1];
      end
   end

   // Bit capture: a frame only opens on a seen nCS fall, so a frame already
   // running when reset is released stays ignored until nCS goes high.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         in_frame  <= 1'b0;
         bit_cnt   <= 4'd0;
         shift_in  <= 8'h00;
         byte_done <= 1'b0;
      end else begin
         byte_done <= 1'b0;
         if (ncs_fall) begin
            in_frame <= 1'b1;
            bit_cnt  <= 4'd0;
         end else if (ncs_rise) begin
            in_frame <= 1'b0;
         end else if (in_frame && sclk_rise && (bit_cnt != 4'd8)) begin
            shift_in <= {shift_in[6:0], sdi_sync[1]};
            bit_cnt  <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
               byte_done <= 1'b1;
            end
         end
      end
   end

   // FSM state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_CMD;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode and strobe requests for a completed or aborted byte.
   always_comb begin
      state_nxt = state;
      we_nxt    = 1'b0;
      re_nxt    = 1'b0;
      err_nxt   = 1'b0;
      abort_nxt = 1'b0;
      addr_ld   = 1'b0;
      wdata_ld  = 1'b0;
      if (abort_cond) begin
         abort_nxt = 1'b1;
         state_nxt = S_CMD;
      end else if (byte_done) begin
         case (state)
            S_CMD: begin
               if (shift_in == SET_ADDR_CMD) begin
                  state_nxt = S_ADDR;
               end else if (shift_in == WRITE_CMD) begin
                  state_nxt = S_WDATA;
               end else if (shift_in == READ_CMD) begin
                  state_nxt = S_RDATA;
                  re_nxt    = 1'b1;
               end else begin
                  err_nxt = 1'b1;
               end
            end
            S_ADDR: begin
               addr_ld   = 1'b1;
               state_nxt = S_CMD;
            end
            S_WDATA: begin
               wdata_ld  = 1'b1;
               we_nxt    = 1'b1;
               state_nxt = S_CMD;
            end
            default: begin
               state_nxt = S_CMD;
            end
         endcase
      end
   end

   // Registered one-cycle strobes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         reg_we      <= 1'b0;
         reg_re      <= 1'b0;
         cmd_err     <= 1'b0;
         frame_abort <= 1'b0;
      end else begin
         reg_we      <= we_nxt;
         reg_re      <= re_nxt;
         cmd_err     <= err_nxt;
         frame_abort <= abort_nxt;
      end
   end

`ifdef SI53XX_RESP_AUTOINC_EN
   logic rd_done;
   assign rd_done = byte_done && (state == S_RDATA) && !abort_cond;
`endif

   // Address and write-data registers; reg_addr is stable while reg_we is high.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         reg_addr  <= 8'h00;
         reg_wdata <= 8'h00;
      end else begin
         if (addr_ld) begin
            reg_addr <= shift_in;
`ifdef SI53XX_RESP_AUTOINC_EN
         end else if (reg_we || rd_done) begin
            reg_addr <= reg_addr + 8'd1;
`endif
         end
         if (wdata_ld) begin
            reg_wdata <= shift_in;
         end
      end
   end

   // Read path: capture reg_rdata one cycle after reg_re, drive it out on
   // the next frame, stepping to the following bit on each sclk fall.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         re_dly   <= 1'b0;
         rd_shift <= 8'h00;
         sdo_oe   <= 1'b0;
      end else begin
         re_dly <= reg_re;
         if (ncs_rise) begin
            sdo_oe <= 1'b0;
         end else if (ncs_fall && (state == S_RDATA)) begin
            sdo_oe <= 1'b1;
         end
         if (re_dly) begin
            rd_shift <= reg_rdata;
         end else if (sdo_oe && sclk_fall && (state == S_RDATA)) begin
            rd_shift <= RD_LSB_FIRST ? {1'b0, rd_shift[7:1]} : {rd_shift[6:0], 1'b0};
         end
      end
   end

endmodule
`default_nettype wire

// File: doc/si53xx_spi_responder.md
SI53XX_SPI_RESPONDER -- requirements
Module: si53xx_spi_responder

Interface
REQ-001 SHALL have parameter SET_ADDR_CMD, default 8'h15, command byte selecting an address load.
REQ-002 SHALL have parameter WRITE_CMD, default 8'h4A, command byte selecting a data write.
REQ-003 SHALL have parameter READ_CMD, default 8'h95, command byte selecting a data read.
REQ-004 SHALL have parameter RD_LSB_FIRST, default 1, where 1 shifts read data out LSB first and 0 shifts it MSB first.
REQ-005 clk  input  1  system clock; all logic is on the rising edge; single clock domain.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 nCS  input  1  SPI chip select, active low; one byte per low period.
REQ-008 sclk  input  1  SPI clock, idle low.
REQ-009 sdi  input  1  serial data from the initiator, MSB first.
REQ-010 sdo  output  1  serial data to the initiator.
REQ-011 sdo_oe  output  1  sdo drive enable.
REQ-012 reg_addr  output  8  register address.
REQ-013 reg_wdata  output  8  register write data.
REQ-014 reg_we  output  1  write strobe, one cycle wide.
REQ-015 reg_re  output  1  read strobe, one cycle wide.
REQ-016 reg_rdata  input  8  register read data, valid on the cycle after reg_re.
REQ-017 cmd_err  output  1  one-cycle pulse on an unrecognised command byte.
REQ-018 frame_abort  output  1  one-cycle pulse when nCS rises with 1-7 bits received.

Function
REQ-019 SHALL pass nCS, sclk and sdi through 2-flop synchronisers, then detect sclk rise/fall and nCS fall/rise on the synchronised signals.
REQ-020 SHALL require an sclk half-period of at least 4 clk cycles.
REQ-021 SHALL sample sdi on each detected sclk rise while nCS is low, shifting MSB first; a 4-bit counter SHALL count 0..8.
REQ-022 SHALL reset the bit counter to 0 on nCS fall; bits after the 8th within the same frame SHALL be ignored.
REQ-023 SHALL implement an FSM with states S_CMD, S_ADDR, S_WDATA and S_RDATA, advanced on the cycle after the 8th bit is sampled ("byte done").
REQ-024 In S_CMD, byte == SET_ADDR_CMD -> S_ADDR; WRITE_CMD -> S_WDATA; READ_CMD -> S_RDATA with a reg_re pulse; any other value -> cmd_err pulse, remain in S_CMD.
REQ-025 In S_ADDR, byte done SHALL load reg_addr with the byte and go to S_CMD.
REQ-026 In S_WDATA, byte done SHALL put the byte on reg_wdata, pulse reg_we for exactly 1 cycle with reg_addr unchanged, and go to S_CMD.
REQ-027 On the cycle after reg_re, the read shift register SHALL capture reg_rdata.
REQ-028 In S_RDATA, on nCS fall, sdo_oe SHALL be set to 1 and sdo SHALL present the first bit (bit0 if RD_LSB_FIRST, else bit7).
REQ-029 In S_RDATA, each sclk fall SHALL advance sdo to the next bit; sdi bits are still shifted but discarded; byte done -> S_CMD.
REQ-030 sdo_oe SHALL drop to 0 on nCS rise in every state; sdo SHALL be 0 whenever sdo_oe is 0.
REQ-031 nCS rise with 1-7 bits received SHALL pulse frame_abort, discard the partial byte and force S_CMD, without issuing reg_we or reg_re.
REQ-032 nCS rise with 0 bits received SHALL be ignored.
REQ-033 nCS rise on the same cycle as byte done SHALL count as a completed byte.
REQ-034 reg_we and reg_re SHALL never be asserted on the same cycle.

Reset
REQ-035 Asserting reset SHALL force S_CMD, clear the bit counter, synchronisers and shift registers, and drive sdo, sdo_oe, reg_we, reg_re, cmd_err and frame_abort to 0.
REQ-036 Asserting reset SHALL force reg_addr and reg_wdata to 8'h00.
REQ-037 Reset mid-frame SHALL discard the frame.
REQ-038 After reset release, the first nCS fall SHALL start a fresh command byte; a frame already in progress at release SHALL be ignored until nCS rises.

Configuration
REQ-039 With SI53XX_RESP_AUTOINC_EN defined, reg_addr SHALL increment by 1, wrapping 8'hFF -> 8'h00, on the cycle after each reg_we.
REQ-040 With SI53XX_RESP_AUTOINC_EN defined, reg_addr SHALL also increment by 1 on each completed S_RDATA byte.
REQ-041 Without SI53XX_RESP_AUTOINC_EN, reg_addr SHALL change only in S_ADDR or on reset.

Verification
REQ-042 Frames 15,3C,4A,A5 -> exactly one reg_we, with reg_addr=3C and reg_wdata=A5; FSM ends in S_CMD.
REQ-043 Frames 15,10,95,00 with reg_rdata=8'h81 -> reg_re once; the sdo sequence is 1,0,0,0,0,0,0,1 LSB first; sdo_oe is high only during the 4th frame.
REQ-044 Command byte 8'h33 -> cmd_err pulses once; the next frame 4A is decoded as a write command.
REQ-045 nCS raised after 5 bits of an S_WDATA byte -> frame_abort pulses, no reg_we; the next frame 15 is accepted.
REQ-046 AUTOINC_EN: addr FF, then write 11 and write 22 -> reg_we at FF then 00, with reg_addr 01 afterwards.
REQ-047 Reset asserted mid-read frame -> all outputs 0 within 1 cycle; the post-release frame 15 is accepted.
